pong_score_keeper: RTL and testbench
====================================

Name: pong_score_keeper

Overview:
- Scoring and game-flow controller for vPong; produces the 4-bit per-player score values consumed by the score-digit renderers.
- Takes goal events from the ball/collision logic and a frame tick from the VGA timing block.
- Sequences idle, serve countdown, play and game over.
- Score outputs change only on frame boundaries, so a digit never changes mid-frame.

Parameters:
- WIN_SCORE, 9, score that ends the game; legal range 1..9 because the renderers draw a single decimal digit.
- SERVE_FRAMES, 60, number of frame ticks the ball is held before each serve; legal range 1..255.

Ports:
- clk  input  1  system clock, same clock as the VGA pixel counters.
- reset  input  1  synchronous, active-high reset.
- frame_tick  input  1  one-cycle pulse once per frame, at start of vertical blanking.
- goal_p1  input  1  one-cycle pulse: ball left the field past player 2 (bottom), so player 1 scores.
- goal_p2  input  1  one-cycle pulse: ball left the field past player 1 (top), so player 2 scores.
- start_btn  input  1  start/restart request, already synchronised and debounced; level or pulse.
- point1  output  4  player 1 score, 0..WIN_SCORE.
- point2  output  4  player 2 score, 0..WIN_SCORE.
- ball_enable  output  1  1 = ball may move; 0 = ball logic holds the ball at centre.
- serve_dir  output  1  0 = serve toward player 1 (up); 1 = serve toward player 2 (down).
- game_over  output  1  1 while in GAME_OVER.
- winner  output  2  00 none, 01 player 1, 10 player 2; held through GAME_OVER.

Behaviour:
- Reset (synchronous; wins over every other input, including mid-serve or mid-play):
  - State goes to IDLE.
  - point1 = point2 = 0, ball_enable = 0, serve_dir = 0, game_over = 0, winner = 00.
  - Pending goal flags and serve counter cleared.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, SERVE, PLAY, GAME_OVER.
- IDLE:
  - ball_enable = 0; goals ignored.
  - start_btn = 1 on an edge: next state SERVE, serve_cnt = SERVE_FRAMES-1, serve_dir = 0.
- SERVE:
  - ball_enable = 0; goals ignored.
  - On each frame_tick: if serve_cnt == 0, go to PLAY; otherwise decrement serve_cnt.
  - SERVE therefore lasts exactly SERVE_FRAMES frame ticks.
  - start_btn ignored.
- PLAY:
  - ball_enable = 1.
  - On an edge with exactly one of goal_p1/goal_p2 high and no goal pending: set pend1 or pend2. ball_enable goes to 0 on the following cycle.
  - On an edge with goal_p1 and goal_p2 both high (simultaneous): no score. Set pend_none so the state leaves PLAY at the next frame_tick; serve_dir is unchanged.
  - While any flag is pending, further goal pulses are ignored.
  - A goal arriving in the same cycle as frame_tick is latched only. It is applied at the next frame_tick, never the current one.
  - On a frame_tick with a flag pending:
    - Scorer's point increments by 1 on that edge.
    - Pending flags clear.
    - If the new score == WIN_SCORE: go to GAME_OVER, winner = scorer.
    - Otherwise: go to SERVE, serve_cnt = SERVE_FRAMES-1, serve_dir = toward the conceding player (player 1 scored gives 1; player 2 scored gives 0).
  - start_btn ignored.
- GAME_OVER:
  - ball_enable = 0, game_over = 1; scores and winner frozen; goals ignored.
  - start_btn = 1 on an edge: point1 = point2 = 0, winner = 00, game_over = 0, go to SERVE with serve_dir = 0.
- Arithmetic:
  - Scores are 4-bit and saturate at WIN_SCORE; they never wrap.
  - No increment is ever applied outside the PLAY to SERVE/GAME_OVER transition.
- Invariant: point1/point2 change only on an edge where frame_tick = 1, or on the start edge in GAME_OVER. That start edge happens while no ball is drawn.

Test Plan:
1. Reset held 3 cycles, then start_btn pulse, SERVE_FRAMES = 4 → point1 = point2 = 0; ball_enable rises the cycle after the 4th frame_tick; serve_dir = 0.
2. In PLAY, goal_p1 mid-frame → ball_enable = 0 next cycle; point1 stays 0 until the next frame_tick edge, then 1; serve_dir = 1; SERVE lasts 4 ticks.
3. goal_p2 asserted in the same cycle as frame_tick → no change on that tick; point2 = 1 on the following frame_tick.
4. goal_p1 and goal_p2 together → at the next frame_tick, scores unchanged, state SERVE, serve_dir unchanged. A second goal_p2 while pending is ignored (point2 unchanged).
5. Drive player 1 to WIN_SCORE = 9 → point1 = 9, game_over = 1, winner = 01, ball_enable = 0. Further goals/frame ticks leave everything unchanged. start_btn → scores 0, winner 00, SERVE.
6. Reset asserted in PLAY with point1 = 5 and pend2 set → next cycle IDLE, all outputs at reset values; following frame_tick causes no increment.

Source files
------------

// File: rtl/pong_score_keeper.sv
// vPong score keeper: serve countdown, frame-aligned scoring,
// win detection and restart sequencing.
module pong_score_keeper #(
   parameter int WIN_SCORE    = 9,
   parameter int SERVE_FRAMES = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       goal_p1,
   input  logic       goal_p2,
   input  logic       start_btn,
   output logic [3:0] point1,
   output logic [3:0] point2,
   output logic       ball_enable,
   output logic       serve_dir,
   output logic       game_over,
   output logic [1:0] winner
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SERVE,
      S_PLAY,
      S_OVER
   } state_t;

   localparam logic [3:0] WIN        = 4'(WIN_SCORE);
   localparam logic [7:0] SERVE_INIT = 8'(SERVE_FRAMES - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       pend1_q, pend1_d;
   logic       pend2_q, pend2_d;
   logic       pendn_q, pendn_d;
   logic [3:0] p1_q, p1_d;
   logic [3:0] p2_q, p2_d;
   logic       dir_q, dir_d;
   logic       be_q, be_d;
   logic       go_q, go_d;
   logic [1:0] win_q, win_d;

   logic       any_pend;
   logic [3:0] p1_inc;
   logic [3:0] p2_inc;

   assign any_pend = pend1_q | pend2_q | pendn_q;
   assign p1_inc   = (p1_q >= WIN) ? WIN : p1_q + 4'd1;
   assign p2_inc   = (p2_q >= WIN) ? WIN : p2_q + 4'd1;

   // State register and registered outputs; reset wins over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pend1_q <= 1'b0;
         pend2_q <= 1'b0;
         pendn_q <= 1'b0;
         p1_q    <= '0;
         p2_q    <= '0;
         dir_q   <= 1'b0;
         be_q    <= 1'b0;
         go_q    <= 1'b0;
         win_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend1_q <= pend1_d;
         pend2_q <= pend2_d;
         pendn_q <= pendn_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         dir_q   <= dir_d;
         be_q    <= be_d;
         go_q    <= go_d;
         win_q   <= win_d;
      end
   end

   // Next-state logic; goals are only latched in PLAY and applied on a
   // later frame tick so the digits never change mid-frame.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend1_d = pend1_q;
      pend2_d = pend2_q;
      pendn_d = pendn_q;
      p1_d    = p1_q;
      p2_d    = p2_q;
      dir_d   = dir_q;
      win_d   = win_q;

      unique case (state_q)
         S_IDLE: begin
            if (start_btn) begin
               state_d = S_SERVE;
               cnt_d   = SERVE_INIT;
               dir_d   = 1'b0;
            end
         end
         S_SERVE: begin
            if (frame_tick) begin
               if (cnt_q == 8'd0) state_d = S_PLAY;
               else               cnt_d   = cnt_q - 8'd1;
            end
         end
         S_PLAY: begin
            if (frame_tick && any_pend) begin
               pend1_d = 1'b0;
               pend2_d = 1'b0;
               pendn_d = 1'b0;
               state_d = S_SERVE;
               cnt_d   = SERVE_INIT;
               if (pend1_q) begin
                  p1_d  = p1_inc;
                  dir_d = 1'b1;
                  if (p1_inc == WIN) begin
                     state_d = S_OVER;
                     win_d   = 2'b01;
                     dir_d   = dir_q;
                  end
               end else if (pend2_q) begin
                  p2_d  = p2_inc;
                  dir_d = 1'b0;
                  if (p2_inc == WIN) begin
                     state_d = S_OVER;
                     win_d   = 2'b10;
                     dir_d   = dir_q;
                  end
               end
            end else if (!any_pend) begin
               if (goal_p1 && goal_p2) pendn_d = 1'b1;
               else if (goal_p1)       pend1_d = 1'b1;
               else if (goal_p2)       pend2_d = 1'b1;
            end
         end
         S_OVER: begin
            if (start_btn) begin
               p1_d    = '0;
               p2_d    = '0;
               win_d   = 2'b00;
               state_d = S_SERVE;
               cnt_d   = SERVE_INIT;
               dir_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      go_d = (state_d == S_OVER);
      be_d = (state_d == S_PLAY) && !(pend1_d || pend2_d || pendn_d);
   end

   assign point1      = p1_q;
   assign point2      = p2_q;
   assign ball_enable = be_q;
   assign serve_dir   = dir_q;
   assign game_over   = go_q;
   assign winner      = win_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Bench for pong_score_keeper: vector table of per-cycle inputs and
// expected registered outputs, checked through a scoreboard queue.
module tb_pong_score_keeper;

   logic       clk;
   logic       reset;
   logic       frame_tick;
   logic       goal_p1;
   logic       goal_p2;
   logic       start_btn;
   logic [3:0] point1;
   logic [3:0] point2;
   logic       ball_enable;
   logic       serve_dir;
   logic       game_over;
   logic [1:0] winner;

   pong_score_keeper #(
      .WIN_SCORE   (9),
      .SERVE_FRAMES(4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .goal_p1    (goal_p1),
      .goal_p2    (goal_p2),
      .start_btn  (start_btn),
      .point1     (point1),
      .point2     (point2),
      .ball_enable(ball_enable),
      .serve_dir  (serve_dir),
      .game_over  (game_over),
      .winner     (winner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       st;
      logic       ft;
      logic       g1;
      logic       g2;
      logic [3:0] p1;
      logic [3:0] p2;
      logic       be;
      logic       sd;
      logic       go;
      logic [1:0] w;
   } vec_t;

   vec_t        tbl[$];
   logic [12:0] exp_q[$];
   int          idx_q[$];
   int          checks = 0;
   int          errors = 0;

   task automatic add(input logic rst, input logic st, input logic ft,
                      input logic g1, input logic g2,
                      input int p1, input int p2,
                      input logic be, input logic sd, input logic go,
                      input logic [1:0] w);
      vec_t v;
      v.rst = rst; v.st = st; v.ft = ft; v.g1 = g1; v.g2 = g2;
      v.p1 = 4'(p1); v.p2 = 4'(p2);
      v.be = be; v.sd = sd; v.go = go; v.w = w;
      tbl.push_back(v);
   endtask

   // Player 1 scores point k from PLAY: latch, apply, 4-tick serve.
   task automatic p1_point(input int k, input int p2, input logic sd0);
      add(0,0,0,1,0, k-1,p2, 0,sd0,0,2'b00);
      add(0,0,1,0,0, k,  p2, 0,1,  0,2'b00);
      repeat (3) add(0,0,1,0,0, k,p2, 0,1,0,2'b00);
      add(0,0,1,0,0, k,  p2, 1,1,  0,2'b00);
   endtask

   task automatic compare();
      logic [12:0] act;
      logic [12:0] exp;
      int          idx;
      exp = exp_q.pop_front();
      idx = idx_q.pop_front();
      act = {point1, point2, ball_enable, serve_dir, game_over, winner};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL vec%0d p1/p2/be/sd/go/win got %0d/%0d/%b/%b/%b/%b want %0d/%0d/%b/%b/%b/%b",
                  idx, act[12:9], act[8:5], act[4], act[3], act[2], act[1:0],
                  exp[12:9], exp[8:5], exp[4], exp[3], exp[2], exp[1:0]);
      end
   endtask

   initial begin
      reset = 1'b0; frame_tick = 1'b0; goal_p1 = 1'b0;
      goal_p2 = 1'b0; start_btn = 1'b0;

      // reset, start, 4-tick serve
      repeat (3) add(1,0,0,0,0, 0,0, 0,0,0,2'b00);
      add(0,1,0,0,0, 0,0, 0,0,0,2'b00);
      add(0,0,0,0,0, 0,0, 0,0,0,2'b00);
      repeat (3) add(0,0,1,0,0, 0,0, 0,0,0,2'b00);
      add(0,0,1,0,0, 0,0, 1,0,0,2'b00);
      // p1 goal mid-frame, extra goal while pending ignored
      add(0,0,0,0,0, 0,0, 1,0,0,2'b00);
      add(0,0,0,1,0, 0,0, 0,0,0,2'b00);
      add(0,0,0,0,0, 0,0, 0,0,0,2'b00);
      add(0,0,0,0,1, 0,0, 0,0,0,2'b00);
      add(0,0,1,0,0, 1,0, 0,1,0,2'b00);
      repeat (3) add(0,0,1,0,0, 1,0, 0,1,0,2'b00);
      add(0,0,1,0,0, 1,0, 1,1,0,2'b00);
      // p2 goal coincident with frame tick
      add(0,0,1,0,1, 1,0, 0,1,0,2'b00);
      add(0,0,0,0,0, 1,0, 0,1,0,2'b00);
      add(0,0,1,0,0, 1,1, 0,0,0,2'b00);
      repeat (3) add(0,0,1,0,0, 1,1, 0,0,0,2'b00);
      add(0,0,1,0,0, 1,1, 1,0,0,2'b00);
      p1_point(2, 1, 1'b0);
      // simultaneous goals: no score, serve_dir kept
      add(0,0,0,1,1, 2,1, 0,1,0,2'b00);
      add(0,0,0,0,1, 2,1, 0,1,0,2'b00);
      add(0,0,1,0,0, 2,1, 0,1,0,2'b00);
      repeat (3) add(0,0,1,0,0, 2,1, 0,1,0,2'b00);
      add(0,0,1,0,0, 2,1, 1,1,0,2'b00);
      add(0,1,0,0,0, 2,1, 1,1,0,2'b00);
      // player 1 runs to the winning score
      for (int k = 3; k <= 8; k++) p1_point(k, 1, 1'b1);
      add(0,0,0,1,0, 8,1, 0,1,0,2'b00);
      add(0,0,1,0,0, 9,1, 0,1,1,2'b01);
      add(0,0,0,0,1, 9,1, 0,1,1,2'b01);
      add(0,0,1,0,0, 9,1, 0,1,1,2'b01);
      add(0,0,1,1,0, 9,1, 0,1,1,2'b01);
      add(0,0,0,0,0, 9,1, 0,1,1,2'b01);
      add(0,1,0,0,0, 0,0, 0,0,0,2'b00);
      repeat (3) add(0,0,1,0,0, 0,0, 0,0,0,2'b00);
      add(0,0,1,0,0, 0,0, 1,0,0,2'b00);
      // reset in PLAY with point1 = 5 and pend2 set
      for (int k = 1; k <= 5; k++) p1_point(k, 0, k > 1);
      add(0,0,0,0,1, 5,0, 0,1,0,2'b00);
      add(1,0,0,0,0, 0,0, 0,0,0,2'b00);
      add(0,0,1,0,0, 0,0, 0,0,0,2'b00);
      add(0,0,1,1,0, 0,0, 0,0,0,2'b00);
      // reset beats start, reset mid-serve, then a clean serve
      add(1,1,0,0,0, 0,0, 0,0,0,2'b00);
      add(0,1,0,0,0, 0,0, 0,0,0,2'b00);
      add(0,0,1,0,0, 0,0, 0,0,0,2'b00);
      add(1,0,1,0,0, 0,0, 0,0,0,2'b00);
      repeat (5) add(0,0,1,0,0, 0,0, 0,0,0,2'b00);
      add(0,1,0,0,0, 0,0, 0,0,0,2'b00);
      repeat (3) add(0,0,1,0,0, 0,0, 0,0,0,2'b00);
      add(0,0,1,0,0, 0,0, 1,0,0,2'b00);

      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) compare();
         reset      = tbl[i].rst;
         start_btn  = tbl[i].st;
         frame_tick = tbl[i].ft;
         goal_p1    = tbl[i].g1;
         goal_p2    = tbl[i].g2;
         exp_q.push_back({tbl[i].p1, tbl[i].p2, tbl[i].be,
                          tbl[i].sd, tbl[i].go, tbl[i].w});
         idx_q.push_back(i);
      end
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) compare();
      reset = 1'b0; start_btn = 1'b0; frame_tick = 1'b0;
      goal_p1 = 1'b0; goal_p2 = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
